pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. Works alongside the forwarding unit. Covers the cases that forwarding cannot resolve:
- load-use hazards
- icache misses
- dcache waits
- taken branches and jumps
- halt drain
It drives the per-latch enable/flush controls and keeps saturating performance counters.

---
 rtl/pipeline_ctrl_if.sv | 49 ++++
 rtl/pipeline_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs from the datapath, latch controls and counters back.
// master = datapath side, slave = pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
);
  logic             ihit;
  logic             dhit;
  logic             exmem_dREN;
  logic             exmem_dWEN;
  logic             idex_dREN;
  logic [REG_W-1:0] idex_wsel;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             ifid_uses_rt;
  logic             ex_redirect;
  logic             memwb_halt;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             halt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, dhit, exmem_dREN, exmem_dWEN,
    output idex_dREN, idex_wsel, ifid_rs, ifid_rt,
    output ifid_uses_rt, ex_redirect, memwb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, halt,
    input  cyc_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, exmem_dREN, exmem_dWEN,
    input  idex_dREN, idex_wsel, ifid_rs, ifid_rt,
    input  ifid_uses_rt, ex_redirect, memwb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, halt,
    output cyc_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer (load-use, cache waits, redirect, halt).
// Ports: CLK, RST (sync, active high), bus (pipeline_ctrl_if.slave).
module pipeline_ctrl #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  pipeline_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic [REG_W-1:0] wsel, rs, rt;
  logic mem_busy, lu_hazard, redir_fire;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_fl, idex_fl, exmem_fl;

  assign wsel = bus.idex_wsel;
  assign rs   = bus.ifid_rs;
  assign rt   = bus.ifid_rt;

  assign mem_busy = (bus.exmem_dREN | bus.exmem_dWEN) & ~bus.dhit;
  assign lu_hazard = bus.idex_dREN & (wsel != '0) &
    ((wsel == rs) | (bus.ifid_uses_rt & (wsel == rt)));

  // RUN and DWAIT share one decode; DWAIT only differs in name
  always_comb begin
    state_d    = state_q;
    redir_fire = 1'b0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_fl    = 1'b0;
    idex_fl    = 1'b0;
    exmem_fl   = 1'b0;
    if (state_q != HALTED) begin
      priority case (1'b1)
        bus.memwb_halt: begin
          ifid_fl  = 1'b1;
          idex_fl  = 1'b1;
          exmem_fl = 1'b1;
          state_d  = HALTED;
        end
        mem_busy: begin
          state_d = DWAIT;
        end
        bus.ex_redirect: begin
          {pc_en, ifid_en, idex_en} = '1;
          {exmem_en, memwb_en}      = '1;
          ifid_fl    = 1'b1;
          idex_fl    = 1'b1;
          redir_fire = 1'b1;
          state_d    = RUN;
        end
        lu_hazard: begin
          // one bubble: the load is gone from EX next cycle
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          idex_fl  = 1'b1;
          state_d  = RUN;
        end
        ~bus.ihit: begin
          {ifid_en, idex_en} = '1;
          {exmem_en, memwb_en} = '1;
          ifid_fl = 1'b1;
          state_d = RUN;
        end
        default: begin
          {pc_en, ifid_en, idex_en} = '1;
          {exmem_en, memwb_en}      = '1;
          state_d = RUN;
        end
      endcase
    end
    if (RST) begin
      {pc_en, ifid_en, idex_en} = '0;
      {exmem_en, memwb_en}      = '0;
      {ifid_fl, idex_fl, exmem_fl} = '0;
      redir_fire = 1'b0;
      state_d    = RUN;
    end
  end

  always_comb begin
    cyc_d   = cyc_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (state_q != HALTED) begin
      if (cyc_q != '1)
        cyc_d = cyc_q + 1'b1;
      if (!pc_en && stall_q != '1)
        stall_d = stall_q + 1'b1;
      if (redir_fire && flush_q != '1)
        flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_fl;
  assign bus.idex_flush  = idex_fl;
  assign bus.exmem_flush = exmem_fl;
  // reset forces halt and counters low in the reset cycle itself
  assign bus.halt      = (state_q == HALTED) & ~RST;
  assign bus.cyc_cnt   = RST ? '0 : cyc_q;
  assign bus.stall_cnt = RST ? '0 : stall_q;
  assign bus.flush_cnt = RST ? '0 : flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: random + directed stimulus against a priority-rule model.
// Small CNT_W so counter saturation is reachable.
module tb_pipeline_ctrl;
  localparam int CW   = 6;
  localparam int MAXV = (1 << CW) - 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bit   m_halt;
  int   m_cyc, m_stall, m_flush;

  pipeline_ctrl_if #(.CNT_W(CW), .REG_W(5)) dif ();

  pipeline_ctrl #(.CNT_W(CW), .REG_W(5)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (dif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // [9]=redirect taken, [8]=pc_en, [7:4]=latch en,
  // [3:1]=ifid/idex/exmem flush, [0]=halt
  function automatic logic [9:0] model_ctl();
    bit mb, lu;
    if (rst) return 10'b0;
    if (m_halt) return 10'b0_00000_000_1;
    mb = (dif.exmem_dREN | dif.exmem_dWEN) & ~dif.dhit;
    lu = dif.idex_dREN && dif.idex_wsel != 0 &&
         (dif.idex_wsel == dif.ifid_rs ||
          (dif.ifid_uses_rt && dif.idex_wsel == dif.ifid_rt));
    if (dif.memwb_halt) return 10'b0_00000_111_0;
    if (mb) return 10'b0;
    if (dif.ex_redirect) return 10'b1_11111_110_0;
    if (lu) return 10'b0_00111_010_0;
    if (!dif.ihit) return 10'b0_01111_100_0;
    return 10'b0_11111_000_0;
  endfunction

  function automatic int sat(input int v);
    return (v >= MAXV) ? MAXV : v + 1;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic [9:0] e;
    logic [8:0] a;
    e = model_ctl();
    a = {dif.pc_en, dif.ifid_en, dif.idex_en, dif.exmem_en,
         dif.memwb_en, dif.ifid_flush, dif.idex_flush,
         dif.exmem_flush, dif.halt};
    cmp("ctl", int'(a), int'(e[8:0]));
    cmp("cyc_cnt", int'(dif.cyc_cnt), rst ? 0 : m_cyc);
    cmp("stall_cnt", int'(dif.stall_cnt), rst ? 0 : m_stall);
    cmp("flush_cnt", int'(dif.flush_cnt), rst ? 0 : m_flush);
    if (rst) begin
      m_halt  = 1'b0;
      m_cyc   = 0;
      m_stall = 0;
      m_flush = 0;
    end else if (!m_halt) begin
      m_cyc = sat(m_cyc);
      if (!e[8]) m_stall = sat(m_stall);
      if (e[9])  m_flush = sat(m_flush);
      if (dif.memwb_halt) m_halt = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit ih, input bit dh,
                       input bit dr, input bit dw, input bit ld,
                       input logic [4:0] ws, input logic [4:0] rs,
                       input logic [4:0] rt, input bit ur,
                       input bit rd, input bit mh);
    rst              = r;
    dif.ihit         = ih;
    dif.dhit         = dh;
    dif.exmem_dREN   = dr;
    dif.exmem_dWEN   = dw;
    dif.idex_dREN    = ld;
    dif.idex_wsel    = ws;
    dif.ifid_rs      = rs;
    dif.ifid_rt      = rt;
    dif.ifid_uses_rt = ur;
    dif.ex_redirect  = rd;
    dif.memwb_halt   = mh;
  endtask

  task automatic idle();
    drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    tick();
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_halt   = 0;
    m_cyc    = 0;
    m_stall  = 0;
    m_flush  = 0;
    drive(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();
    cmp("rst_halt", int'(dif.halt), 0);
    cmp("rst_cyc", int'(dif.cyc_cnt), 0);
    cmp("rst_pc_en", int'(dif.pc_en), 0);

    // load-use on rs
    drive(0, 1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd7, 1, 0, 0);
    #1;
    cmp("lu_out", int'({dif.pc_en, dif.ifid_en, dif.idex_flush}), 1);
    tick();
    idle();
    #1;
    cmp("lu_next", int'(dif.pc_en), 1);
    tick();
    cmp("lu_stall", int'(dif.stall_cnt), 1);
    cmp("lu_cyc", int'(dif.cyc_cnt), 2);

    // rt not read, and $0 destination
    drive(0, 1, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0);
    #1;
    cmp("rt_unused", int'(dif.pc_en), 1);
    tick();
    drive(0, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    #1;
    cmp("reg0", int'(dif.pc_en), 1);
    tick();

    // dcache wait
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0);
      #1;
      cmp("dw_frz", int'({dif.pc_en, dif.ifid_en, dif.idex_en,
                          dif.exmem_en, dif.memwb_en}), 0);
      tick();
    end
    drive(0, 1, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0);
    #1;
    cmp("dw_hit", int'({dif.pc_en, dif.ifid_en, dif.idex_en,
                        dif.exmem_en, dif.memwb_en}), 31);
    tick();
    idle();
    tick();
    cmp("dw_stall", int'(dif.stall_cnt), 3);

    // redirect beats load-use and icache miss
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0);
    #1;
    cmp("rd_prio", int'({dif.pc_en, dif.ifid_flush, dif.idex_flush}), 7);
    tick();
    idle();
    tick();
    cmp("rd_flush", int'(dif.flush_cnt), 1);

    // redirect held under freeze
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0);
      #1;
      cmp("rdf_frz", int'({dif.pc_en, dif.ifid_flush}), 0);
      tick();
    end
    drive(0, 1, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0);
    #1;
    cmp("rdf_go", int'({dif.pc_en, dif.ifid_flush, dif.idex_flush}), 7);
    tick();
    idle();
    tick();
    cmp("rdf_flush", int'(dif.flush_cnt), 1);

    // halt drain
    do_reset();
    idle();
    tick();
    tick();
    drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1);
    #1;
    cmp("hlt_fl", int'({dif.ifid_flush, dif.idex_flush,
                        dif.exmem_flush}), 7);
    tick();
    cmp("hlt_rise", int'({dif.halt, dif.pc_en}), 2);
    for (int i = 0; i < 10; i++) begin
      drive(0, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), 0, $urandom_range(0, 1),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1, $urandom_range(0, 1),
            $urandom_range(0, 1));
      tick();
    end
    cmp("hlt_cyc", int'(dif.cyc_cnt), 3);
    cmp("hlt_stall", int'(dif.stall_cnt), 1);
    cmp("hlt_hold", int'(dif.halt), 1);
    drive(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    #1;
    cmp("hlt_rst", int'({dif.halt, dif.cyc_cnt}), 0);
    tick();

    // saturation
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0);
    for (int i = 0; i < 70; i++) tick();
    cmp("sat_cyc", int'(dif.cyc_cnt), MAXV);
    cmp("sat_stall", int'(dif.stall_cnt), MAXV);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 1),
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 2,
            $urandom_range(0, 1),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            $urandom_range(0, 1),
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 59) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
